// File: rtl/button_mode_ctrl.sv
// rtl/button_mode_ctrl.sv - push-button synchronizer, debouncer, event detector and mode register
module button_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int LONG_PRESS_CYCLES = 25000000,
    parameter bit BTN_ACTIVE_LOW    = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       BTN_IN,
    output logic       BTN_LEVEL,
    output logic       PRESS,
    output logic       RELEASE,
    output logic       LONG_PRESS,
    output logic [1:0] MODE
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES) + 1;
    localparam logic              IDLE_LVL  = BTN_ACTIVE_LOW;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        HELD_LONG,
        DEB_REL
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                long_flag_q, long_flag_d;
    logic                level_q, level_d;
    logic                press_q, press_d;
    logic                release_q, release_d;
    logic                long_q, long_d;
    logic [1:0]          mode_q, mode_d;
    logic                btn_s;

    assign btn_s = BTN_ACTIVE_LOW ? ~sync2_q : sync2_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q     <= IDLE_LVL;
            sync2_q     <= IDLE_LVL;
            state_q     <= IDLE;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            long_flag_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            mode_q      <= 2'd0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_flag_q <= long_flag_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            mode_q      <= mode_d;
        end
    end

    always_comb begin
        sync1_d     = BTN_IN;
        sync2_d     = sync1_q;
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_flag_d = long_flag_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        mode_d      = mode_q;

        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d   = DEB_PRESS;
                    deb_cnt_d = DEB_W'(1);
                end
            end
            DEB_PRESS: begin
                if (!btn_s) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d    = PRESSED;
                    deb_cnt_d  = '0;
                    press_d    = 1'b1;
                    level_d    = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d     = DEB_REL;
                    deb_cnt_d   = DEB_W'(1);
                    long_flag_d = 1'b0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = HELD_LONG;
                    long_d  = 1'b1;
                    mode_d  = 2'd0;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            HELD_LONG: begin
                if (!btn_s) begin
                    state_d     = DEB_REL;
                    deb_cnt_d   = DEB_W'(1);
                    long_flag_d = 1'b1;
                end
            end
            DEB_REL: begin
                // A bounce back to pressed resumes the hold without losing its count.
                if (btn_s) begin
                    state_d   = long_flag_q ? HELD_LONG : PRESSED;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                    if (!long_flag_q) begin
                        mode_d = mode_q + 2'd1;
                    end
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                deb_cnt_d = '0;
            end
        endcase
    end

    assign BTN_LEVEL  = level_q;
    assign PRESS      = press_q;
    assign RELEASE    = release_q;
    assign LONG_PRESS = long_q;
    assign MODE       = mode_q;

endmodule

// File: tb/tb_button_mode_ctrl.sv
// tb/tb_button_mode_ctrl.sv - scoreboard bench for button_mode_ctrl with run-length reference model
module tb_button_mode_ctrl;

    localparam int D = 4;
    localparam int L = 20;

    logic       clk;
    logic       rst_n;
    logic       btn_in;
    logic       btn_level;
    logic       press;
    logic       release_p;
    logic       long_press;
    logic [1:0] mode;

    button_mode_ctrl #(
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L),
        .BTN_ACTIVE_LOW   (1'b1)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .BTN_IN    (btn_in),
        .BTN_LEVEL (btn_level),
        .PRESS     (press),
        .RELEASE   (release_p),
        .LONG_PRESS(long_press),
        .MODE      (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int kind;
        int mode;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  n_press = 0;
    int  n_release = 0;
    int  n_long = 0;
    int  last_press_cyc = 0;

    // model state: raw-pin delay line, accepted level, mismatch run length, hold time
    logic m_p1, m_p2;
    int   m_lvl, m_run, m_hold, m_mode;
    bit   m_long;

    task automatic chk(input bit ok, input string nm, input int act, input int expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p1 = 1'b1; m_p2 = 1'b1;
            m_lvl = 0; m_run = 0; m_hold = 0; m_mode = 0; m_long = 1'b0;
            exp_q.delete();
        end else begin
            int  s;
            bit  was_stable;
            ev_t e;
            s = (m_p2 == 1'b0) ? 1 : 0;
            m_p2 = m_p1;
            m_p1 = btn_in;
            was_stable = (m_run == 0);
            m_run = (s != m_lvl) ? m_run + 1 : 0;
            e.cyc = cyc + 1;
            e.kind = 0;
            if (m_run == D) begin
                m_lvl = s;
                m_run = 0;
                if (s == 1) begin
                    m_hold = 0;
                    m_long = 1'b0;
                    e.kind = 1;
                end else begin
                    if (!m_long) m_mode = (m_mode + 1) % 4;
                    e.kind = 2;
                end
            end else if (m_lvl == 1 && s == 1 && was_stable && !m_long) begin
                if (m_hold == L - 1) begin
                    m_long = 1'b1;
                    m_mode = 0;
                    e.kind = 4;
                end else begin
                    m_hold++;
                end
            end
            if (e.kind != 0) begin
                e.mode = m_mode;
                exp_q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        int  code;
        ev_t e;
        code = {29'd0, long_press, release_p, press};
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            chk(1'b0, "missing_event", 0, e.kind);
        end
        if (code != 0) begin
            if (press) begin n_press++; last_press_cyc = cyc; end
            if (release_p) n_release++;
            if (long_press) n_long++;
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_event", code, 0);
            end else begin
                e = exp_q.pop_front();
                chk(code == e.kind, "event_kind", code, e.kind);
                chk(cyc == e.cyc, "event_cycle", cyc, e.cyc);
                chk(int'(mode) == e.mode, "event_mode", int'(mode), e.mode);
            end
        end
        chk(int'(btn_level) == m_lvl, "btn_level", int'(btn_level), m_lvl);
        chk(int'(mode) == m_mode, "mode", int'(mode), m_mode);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic short_press();
        btn_in = 1'b0; step(10);
        btn_in = 1'b1; step(10);
    endtask

    task automatic check_outputs_zero(input string nm);
        chk({btn_level, press, release_p, long_press, mode} == 6'd0, nm,
            int'({btn_level, press, release_p, long_press, mode}), 0);
    endtask

    initial begin
        int p0, pl, rel_cyc, n;
        bit got;
        rst_n  = 1'b0;
        btn_in = 1'b1;
        step(3);
        check_outputs_zero("reset_outputs");
        rst_n = 1'b1;
        step(10);
        chk(n_press + n_release + n_long == 0, "idle_no_pulses", n_press + n_release + n_long, 0);
        chk(mode == 2'd0, "idle_mode", int'(mode), 0);

        // first clean press: PRESS lands exactly 6 edges after the pin change is driven
        rel_cyc = cyc;
        btn_in = 1'b0; step(8);
        chk(last_press_cyc == rel_cyc + 6, "press_latency", last_press_cyc, rel_cyc + 6);
        btn_in = 1'b1; step(10);
        chk(n_release == 1, "first_release", n_release, 1);
        chk(mode == 2'd1, "mode_after_first", int'(mode), 1);

        p0 = n_press;
        btn_in = 1'b0; step(3);
        for (int i = 0; i < 10; i++) begin
            btn_in = ~btn_in; step(2);
        end
        btn_in = 1'b1; step(12);
        chk(n_press == p0, "bounce_no_press", n_press, p0);
        chk(mode == 2'd1, "bounce_mode", int'(mode), 1);

        rst_n = 1'b0; step(1); rst_n = 1'b1; step(2);
        for (int i = 1; i <= 4; i++) begin
            short_press();
            chk(int'(mode) == (i % 4), "short_press_mode", int'(mode), i % 4);
        end

        short_press();
        short_press();
        chk(mode == 2'd2, "mode_before_long", int'(mode), 2);
        pl = n_long;
        btn_in = 1'b0; step(40);
        chk(n_long == pl + 1, "long_press_seen", n_long, pl + 1);
        chk(mode == 2'd0, "mode_after_long", int'(mode), 0);
        btn_in = 1'b1; step(10);
        chk(mode == 2'd0, "mode_after_long_release", int'(mode), 0);
        short_press();
        chk(mode == 2'd1, "mode_after_long_then_short", int'(mode), 1);

        btn_in = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            step(1);
            got = btn_level;
        end
        chk(got, "wait_level_timeout", int'(got), 1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_press_reset");
        step(2);
        rst_n = 1'b1;
        rel_cyc = cyc;
        p0 = n_press;
        for (int i = 0; i < 50 && n_press == p0; i++) step(1);
        chk(n_press == p0 + 1, "repress_timeout", n_press, p0 + 1);
        chk(last_press_cyc == rel_cyc + 6, "repress_latency", last_press_cyc, rel_cyc + 6);
        chk(mode == 2'd0, "repress_mode", int'(mode), 0);
        btn_in = 1'b1; step(10);

        for (int i = 0; i < 250; i++) begin
            btn_in = 1'($urandom_range(0, 1));
            n = (($urandom & 3) == 0) ? $urandom_range(25, 40) : $urandom_range(1, 12);
            step(n);
        end
        btn_in = 1'b1;
        step(30);
        chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
